// File: rtl/decimal_entry_pkg.sv
// rtl/decimal_entry_pkg.sv - shared types and keypad decode for decimal_entry
package decimal_entry_pkg;

    localparam int KEY_W = 10;

    typedef enum logic [1:0] {
        IDLE,
        ENTRY,
        FULL,
        COMMIT
    } state_t;

    // Keypad order is bit0=0, bit1=9 ... bit9=1; returns {hit, digit}, hit only when exactly one bit is set.
    function automatic logic [4:0] onehot_to_digit(input logic [KEY_W-1:0] k);
        logic [3:0] d;
        int         n;
        d = 4'd0;
        n = 0;
        for (int i = 0; i < KEY_W; i++) begin
            if (k[i]) begin
                n++;
                d = (i == 0) ? 4'd0 : 4'(10 - i);
            end
        end
        return {(n == 1), d};
    endfunction

endpackage

// File: rtl/decimal_entry_if.sv
// rtl/decimal_entry_if.sv - keypad/button inputs and entry/commit outputs of decimal_entry
interface decimal_entry_if
    import decimal_entry_pkg::*;
#(
    parameter int DATA_W = 10,
    parameter int DIG_W  = 2
);
    logic [KEY_W-1:0]  key;
    logic              enter;
    logic              backspace;
    logic              clear;
    logic [DATA_W-1:0] entry;
    logic [DIG_W-1:0]  digits;
    logic [DATA_W-1:0] value;
    logic              valid;
    logic              err;

    modport master (
        output key, enter, backspace, clear,
        input  entry, digits, value, valid, err
    );

    modport slave (
        input  key, enter, backspace, clear,
        output entry, digits, value, valid, err
    );
endinterface

// File: rtl/decimal_entry_key_edge_detect.sv
// rtl/decimal_entry_key_edge_detect.sv - registers inputs and emits one-cycle rising-edge pulses
module key_edge_detect #(
    parameter int W         = 1,
    parameter bit ZERO_PREV = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] pulse
);
    logic [W-1:0] cur_q;
    logic [W-1:0] prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_q  <= '0;
            prev_q <= '0;
        end else begin
            cur_q  <= d;
            prev_q <= cur_q;
        end
    end

    // ZERO_PREV: the whole vector must have been idle, so a key held or slid onto never repeats.
    generate
        if (ZERO_PREV) begin : g_zero_prev
            assign pulse = (prev_q == '0) ? cur_q : '0;
        end else begin : g_bitwise
            assign pulse = cur_q & ~prev_q;
        end
    endgenerate
endmodule

// File: rtl/decimal_entry.sv
// rtl/decimal_entry.sv - keypad decimal number entry with backspace, clear and commit
module decimal_entry
    import decimal_entry_pkg::*;
#(
    parameter int MAX_DIGITS = 3,
    parameter int DATA_W     = 10
) (
    input  logic           clk,
    input  logic           rst,
    decimal_entry_if.slave bus
);
    localparam int DIG_W = $clog2(MAX_DIGITS + 1);

    generate
        if ((1 << DATA_W) <= (10 ** MAX_DIGITS - 1)) begin : g_width_check
            $error("decimal_entry: DATA_W too small for MAX_DIGITS");
        end
    endgenerate

    logic [2:0]       btn_pulse;
    logic [KEY_W-1:0] key_pulse;
    logic             clear_ev;
    logic             enter_ev;
    logic             bs_ev;
    logic [4:0]       key_dec;
    logic             key_hit;
    logic [3:0]       key_digit;

    key_edge_detect #(.W(3), .ZERO_PREV(1'b0)) u_btn_edge (
        .clk   (clk),
        .rst   (rst),
        .d     ({bus.clear, bus.enter, bus.backspace}),
        .pulse (btn_pulse)
    );

    key_edge_detect #(.W(KEY_W), .ZERO_PREV(1'b1)) u_key_edge (
        .clk   (clk),
        .rst   (rst),
        .d     (bus.key),
        .pulse (key_pulse)
    );

    assign clear_ev  = btn_pulse[2];
    assign enter_ev  = btn_pulse[1];
    assign bs_ev     = btn_pulse[0];
    assign key_dec   = onehot_to_digit(key_pulse);
    assign key_hit   = key_dec[4];
    assign key_digit = key_dec[3:0];

    state_t            state_q, state_n;
    logic [DATA_W-1:0] entry_q, entry_n;
    logic [DIG_W-1:0]  digits_q, digits_n;
    logic [DATA_W-1:0] value_q, value_n;
    logic              valid_q, valid_n;
    logic              err_q, err_n;
    logic [DIG_W-1:0]  digits_inc;
    logic [DIG_W-1:0]  digits_dec;

    assign digits_inc = digits_q + DIG_W'(1);
    assign digits_dec = digits_q - DIG_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            entry_q  <= '0;
            digits_q <= '0;
            value_q  <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_n;
            entry_q  <= entry_n;
            digits_q <= digits_n;
            value_q  <= value_n;
            valid_q  <= valid_n;
            err_q    <= err_n;
        end
    end

    // One event per cycle, clear > enter > backspace > digit; losers are dropped.
    always_comb begin
        state_n  = state_q;
        entry_n  = entry_q;
        digits_n = digits_q;
        value_n  = value_q;
        valid_n  = 1'b0;
        err_n    = 1'b0;
        if (state_q == COMMIT) begin
            state_n = IDLE;
        end else if (clear_ev) begin
            state_n  = IDLE;
            entry_n  = '0;
            digits_n = '0;
        end else if (enter_ev) begin
            if (state_q == IDLE) begin
                err_n = 1'b1;
            end else begin
                state_n  = COMMIT;
                value_n  = entry_q;
                valid_n  = 1'b1;
                entry_n  = '0;
                digits_n = '0;
            end
        end else if (bs_ev) begin
            if (state_q == IDLE) begin
                err_n = 1'b1;
            end else begin
                entry_n  = entry_q / DATA_W'(10);
                digits_n = digits_dec;
                state_n  = (digits_dec == '0) ? IDLE : ENTRY;
            end
        end else if (key_hit) begin
            case (state_q)
                IDLE: begin
                    if (key_digit != 4'd0) begin
                        entry_n  = DATA_W'(key_digit);
                        digits_n = DIG_W'(1);
                        state_n  = (MAX_DIGITS == 1) ? FULL : ENTRY;
                    end
                end
                ENTRY: begin
                    entry_n  = DATA_W'(({4'b0, entry_q} << 3) + ({4'b0, entry_q} << 1)
                                       + (DATA_W + 4)'(key_digit));
                    digits_n = digits_inc;
                    state_n  = (digits_inc == DIG_W'(MAX_DIGITS)) ? FULL : ENTRY;
                end
                default: err_n = 1'b1;
            endcase
        end
    end

    assign bus.entry  = entry_q;
    assign bus.digits = digits_q;
    assign bus.value  = value_q;
    assign bus.valid  = valid_q;
    assign bus.err    = err_q;
endmodule

// File: tb/tb_decimal_entry.sv
// tb/tb_decimal_entry.sv - directed self-checking bench for decimal_entry
module tb_decimal_entry;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    decimal_entry_if #(.DATA_W(10), .DIG_W(2)) bus ();

    decimal_entry #(.MAX_DIGITS(3), .DATA_W(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [9:0] key_of(input int d);
        logic [9:0] k;
        k = '0;
        if (d == 0) k[0] = 1'b1;
        else k[10 - d] = 1'b1;
        return k;
    endfunction

    task automatic press(input int d);
        bus.key = key_of(d);
        tick(2);
        bus.key = '0;
        tick(2);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        n_cmp += 5;
        if (bus.entry !== 10'd0) begin $display("FAIL reset_entry got %0d want 0", bus.entry); n_fail++; end
        if (bus.digits !== 2'd0) begin $display("FAIL reset_digits got %0d want 0", bus.digits); n_fail++; end
        if (bus.value !== 10'd0) begin $display("FAIL reset_value got %0d want 0", bus.value); n_fail++; end
        if (bus.valid !== 1'b0) begin $display("FAIL reset_valid got %b want 0", bus.valid); n_fail++; end
        if (bus.err !== 1'b0) begin $display("FAIL reset_err got %b want 0", bus.err); n_fail++; end
    endtask

    task automatic test_basic_commit;
        int exp_e[3] = '{1, 12, 123};
        for (int i = 0; i < 3; i++) begin
            press(i + 1);
            n_cmp += 2;
            if (bus.entry !== 10'(exp_e[i])) begin $display("FAIL basic_entry%0d got %0d want %0d", i, bus.entry, exp_e[i]); n_fail++; end
            if (bus.digits !== 2'(i + 1)) begin $display("FAIL basic_digits%0d got %0d want %0d", i, bus.digits, i + 1); n_fail++; end
        end
        bus.enter = 1'b1;
        tick(1);
        n_cmp++;
        if (bus.valid !== 1'b0) begin $display("FAIL basic_valid_early got %b want 0", bus.valid); n_fail++; end
        tick(1);
        n_cmp += 5;
        if (bus.valid !== 1'b1) begin $display("FAIL basic_valid got %b want 1", bus.valid); n_fail++; end
        if (bus.value !== 10'd123) begin $display("FAIL basic_value got %0d want 123", bus.value); n_fail++; end
        if (bus.entry !== 10'd0) begin $display("FAIL basic_entry_after got %0d want 0", bus.entry); n_fail++; end
        if (bus.digits !== 2'd0) begin $display("FAIL basic_digits_after got %0d want 0", bus.digits); n_fail++; end
        if (bus.err !== 1'b0) begin $display("FAIL basic_err got %b want 0", bus.err); n_fail++; end
        tick(1);
        n_cmp += 2;
        if (bus.valid !== 1'b0) begin $display("FAIL basic_valid_once got %b want 0", bus.valid); n_fail++; end
        if (bus.value !== 10'd123) begin $display("FAIL basic_value_hold got %0d want 123", bus.value); n_fail++; end
        bus.enter = 1'b0;
        tick(2);
    endtask

    task automatic test_leading_zero;
        press(0);
        press(0);
        n_cmp += 2;
        if (bus.entry !== 10'd0) begin $display("FAIL lz_entry got %0d want 0", bus.entry); n_fail++; end
        if (bus.digits !== 2'd0) begin $display("FAIL lz_digits got %0d want 0", bus.digits); n_fail++; end
        press(7);
        n_cmp += 2;
        if (bus.entry !== 10'd7) begin $display("FAIL lz_entry7 got %0d want 7", bus.entry); n_fail++; end
        if (bus.digits !== 2'd1) begin $display("FAIL lz_digits7 got %0d want 1", bus.digits); n_fail++; end
        bus.enter = 1'b1;
        tick(2);
        n_cmp += 2;
        if (bus.valid !== 1'b1) begin $display("FAIL lz_valid got %b want 1", bus.valid); n_fail++; end
        if (bus.value !== 10'd7) begin $display("FAIL lz_value got %0d want 7", bus.value); n_fail++; end
        bus.enter = 1'b0;
        tick(3);
    endtask

    task automatic test_full_err;
        press(9);
        press(9);
        press(9);
        n_cmp += 2;
        if (bus.entry !== 10'd999) begin $display("FAIL full_entry got %0d want 999", bus.entry); n_fail++; end
        if (bus.digits !== 2'd3) begin $display("FAIL full_digits got %0d want 3", bus.digits); n_fail++; end
        bus.key = key_of(5);
        tick(2);
        n_cmp += 3;
        if (bus.err !== 1'b1) begin $display("FAIL full_err got %b want 1", bus.err); n_fail++; end
        if (bus.entry !== 10'd999) begin $display("FAIL full_entry_kept got %0d want 999", bus.entry); n_fail++; end
        if (bus.valid !== 1'b0) begin $display("FAIL full_valid got %b want 0", bus.valid); n_fail++; end
        bus.key = '0;
        tick(1);
        n_cmp++;
        if (bus.err !== 1'b0) begin $display("FAIL full_err_pulse got %b want 0", bus.err); n_fail++; end
        tick(1);
        bus.backspace = 1'b1;
        tick(2);
        n_cmp += 2;
        if (bus.entry !== 10'd99) begin $display("FAIL bs_entry got %0d want 99", bus.entry); n_fail++; end
        if (bus.digits !== 2'd2) begin $display("FAIL bs_digits got %0d want 2", bus.digits); n_fail++; end
        tick(3);
        n_cmp++;
        if (bus.entry !== 10'd99) begin $display("FAIL bs_held got %0d want 99", bus.entry); n_fail++; end
        bus.backspace = 1'b0;
        bus.clear = 1'b1;
        tick(2);
        n_cmp += 4;
        if (bus.entry !== 10'd0) begin $display("FAIL clr_entry got %0d want 0", bus.entry); n_fail++; end
        if (bus.digits !== 2'd0) begin $display("FAIL clr_digits got %0d want 0", bus.digits); n_fail++; end
        if (bus.value !== 10'd7) begin $display("FAIL clr_value got %0d want 7", bus.value); n_fail++; end
        if (bus.valid !== 1'b0 || bus.err !== 1'b0) begin $display("FAIL clr_flags got %b%b want 00", bus.valid, bus.err); n_fail++; end
        bus.clear = 1'b0;
        tick(2);
    endtask

    task automatic test_hold_multihot;
        logic err_seen;
        err_seen = 1'b0;
        bus.key = key_of(4);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            err_seen |= bus.err;
        end
        bus.key = '0;
        tick(2);
        n_cmp += 2;
        if (bus.entry !== 10'd4) begin $display("FAIL hold_entry got %0d want 4", bus.entry); n_fail++; end
        if (bus.digits !== 2'd1) begin $display("FAIL hold_digits got %0d want 1", bus.digits); n_fail++; end
        bus.key = 10'b0000000011;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            err_seen |= bus.err;
        end
        bus.key = '0;
        tick(2);
        n_cmp += 3;
        if (bus.entry !== 10'd4) begin $display("FAIL multi_entry got %0d want 4", bus.entry); n_fail++; end
        if (bus.digits !== 2'd1) begin $display("FAIL multi_digits got %0d want 1", bus.digits); n_fail++; end
        if (err_seen !== 1'b0) begin $display("FAIL multi_err got %b want 0", err_seen); n_fail++; end
        bus.clear = 1'b1;
        tick(2);
        bus.clear = 1'b0;
        tick(2);
    endtask

    task automatic test_idle_errors;
        bus.enter = 1'b1;
        tick(2);
        n_cmp += 3;
        if (bus.err !== 1'b1) begin $display("FAIL idle_enter_err got %b want 1", bus.err); n_fail++; end
        if (bus.valid !== 1'b0) begin $display("FAIL idle_enter_valid got %b want 0", bus.valid); n_fail++; end
        if (bus.value !== 10'd7) begin $display("FAIL idle_enter_value got %0d want 7", bus.value); n_fail++; end
        bus.enter = 1'b0;
        tick(2);
        bus.backspace = 1'b1;
        tick(2);
        n_cmp += 2;
        if (bus.err !== 1'b1) begin $display("FAIL idle_bs_err got %b want 1", bus.err); n_fail++; end
        if (bus.digits !== 2'd0) begin $display("FAIL idle_bs_digits got %0d want 0", bus.digits); n_fail++; end
        bus.backspace = 1'b0;
        tick(2);
        bus.key = key_of(5);
        bus.clear = 1'b1;
        tick(2);
        n_cmp += 3;
        if (bus.entry !== 10'd0) begin $display("FAIL clr_key_entry got %0d want 0", bus.entry); n_fail++; end
        if (bus.digits !== 2'd0) begin $display("FAIL clr_key_digits got %0d want 0", bus.digits); n_fail++; end
        if (bus.err !== 1'b0) begin $display("FAIL clr_key_err got %b want 0", bus.err); n_fail++; end
        bus.key = '0;
        bus.clear = 1'b0;
        tick(2);
        press(3);
        n_cmp++;
        if (bus.entry !== 10'd3) begin $display("FAIL after_clr_entry got %0d want 3", bus.entry); n_fail++; end
        bus.clear = 1'b1;
        tick(2);
        bus.clear = 1'b0;
        tick(2);
    endtask

    task automatic test_rst_commit;
        press(4);
        press(2);
        n_cmp++;
        if (bus.entry !== 10'd42) begin $display("FAIL rc_entry got %0d want 42", bus.entry); n_fail++; end
        bus.enter = 1'b1;
        tick(2);
        n_cmp += 2;
        if (bus.valid !== 1'b1) begin $display("FAIL rc_valid got %b want 1", bus.valid); n_fail++; end
        if (bus.value !== 10'd42) begin $display("FAIL rc_value got %0d want 42", bus.value); n_fail++; end
        rst = 1'b1;
        bus.enter = 1'b0;
        tick(1);
        rst = 1'b0;
        n_cmp += 3;
        if (bus.valid !== 1'b0) begin $display("FAIL rc_valid_rst got %b want 0", bus.valid); n_fail++; end
        if (bus.value !== 10'd0) begin $display("FAIL rc_value_rst got %0d want 0", bus.value); n_fail++; end
        if (bus.entry !== 10'd0) begin $display("FAIL rc_entry_rst got %0d want 0", bus.entry); n_fail++; end
        tick(3);
        n_cmp++;
        if (bus.valid !== 1'b0 || bus.err !== 1'b0) begin $display("FAIL rc_quiet got %b%b want 00", bus.valid, bus.err); n_fail++; end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst = 1'b1;
        bus.key = '0;
        bus.enter = 1'b0;
        bus.backspace = 1'b0;
        bus.clear = 1'b0;
        test_reset();
        test_basic_commit();
        test_leading_zero();
        test_full_err();
        test_hold_multihot();
        test_idle_errors();
        test_rst_commit();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
